// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind a req/ready/rvalid handshake with WAIT_CYCLES wait states.
// Optional MISALIGN_ERR_EN: flag and suppress accesses whose a[1:0] != 0.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rd,
  output logic        err
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            accept, exec;

  logic            we_p0;
  logic [AW-1:0]   idx_p0;
  logic [31:0]     wd_p0;
  logic            mis_p0;

  logic            mis_in;
  logic            exec_we;
  logic [AW-1:0]   exec_idx;
  logic [31:0]     exec_wd;
  logic            exec_mis;

  logic [31:0]     mem [DEPTH];
  logic            unused_bits;

  assign unused_bits = ^{a[31:AW+2], a[1:0]};

`ifdef MISALIGN_ERR_EN
  assign mis_in = |a[1:0];
`else
  assign mis_in = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    rvalid    = 1'b0;
    accept    = 1'b0;
    exec      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          accept  = 1'b1;
          cnt_nxt = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            exec      = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          exec      = 1'b1;
        end
      end
      RESP: begin
        rvalid    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // p0: request captured on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0  <= we;
      idx_p0 <= a[AW+1:2];
      wd_p0  <= wd;
      mis_p0 <= mis_in;
    end
  end

  // With zero wait states the access executes on the accepting edge, straight from the inputs
  always_comb begin
    if (state == IDLE) begin
      exec_we  = we;
      exec_idx = a[AW+1:2];
      exec_wd  = wd;
      exec_mis = mis_in;
    end else begin
      exec_we  = we_p0;
      exec_idx = idx_p0;
      exec_wd  = wd_p0;
      exec_mis = mis_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (exec && exec_we && !exec_mis) begin
      mem[exec_idx] <= exec_wd;
    end
  end

  // p1: response data, held until the next response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd <= 32'd0;
    end else if (exec) begin
      rd <= (exec_we || exec_mis) ? 32'd0 : mem[exec_idx];
    end
  end

`ifdef MISALIGN_ERR_EN
  logic err_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_p1 <= 1'b0;
    end else if (exec) begin
      err_p1 <= exec_mis;
    end
  end

  assign err = err_p1;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance,
// both checked against an array model of word-addressed memory.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WC    = 2;
`ifdef MISALIGN_ERR_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] a, wd;
  logic        ready, rvalid, err;
  logic [31:0] rd;
  logic        req0, we0;
  logic [31:0] a0, wd0;
  logic        ready0, rvalid0, err0;
  logic [31:0] rd0;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model [DEPTH];
  bit          known [DEPTH];

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .a(a), .wd(wd),
    .ready(ready), .rvalid(rvalid), .rd(rd), .err(err)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .a(a0), .wd(wd0),
    .ready(ready0), .rvalid(rvalid0), .rd(rd0), .err(err0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int widx(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  // Reference: what the response should carry, and the memory effect
  task automatic ref_op(input bit w, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] exp_rd, output logic exp_err);
    bit mis;
    mis     = MIS_EN && (addr % 4 != 0);
    exp_err = mis;
    exp_rd  = 32'd0;
    if (w) begin
      if (!mis) begin
        model[widx(addr)] = data;
        known[widx(addr)] = 1'b1;
      end
    end else if (!mis) begin
      exp_rd = model[widx(addr)];
    end
  endtask

  // Drives one transaction on the WAIT_CYCLES=2 instance and reports what it saw
  task automatic access(input bit w, input logic [31:0] addr, input logic [31:0] data,
                        input bit noise, output int lat, output int busy_bad,
                        output logic [31:0] got_rd, output logic got_err,
                        output logic start_ready);
    @(negedge clk);
    start_ready = ready;
    req = 1'b1; we = w; a = addr; wd = data;
    lat = -1; busy_bad = 0; got_rd = 'x; got_err = 1'bx;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (ready !== 1'b0) busy_bad++;
      if (rvalid === 1'b1) begin
        lat = n; got_rd = rd; got_err = err;
        req = 1'b0; we = 1'b0;
        break;
      end
      if (noise) begin
        req = 1'b1; we = 1'b1; a = 32'h20; wd = $urandom;
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    int lat, busy_bad;
    logic [31:0] got_rd, exp_rd;
    logic got_err, exp_err, sr;
    reset = 1'b0; req = 0; we = 0; a = 0; wd = 0; req0 = 0; we0 = 0; a0 = 0; wd0 = 0;
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_rd: got %h want 0", rd); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (ready0 !== 1'b1 || rvalid0 !== 1'b0) begin
      miscompares++; $display("FAIL reset_dut0: got ready=%b rvalid=%b want 1/0", ready0, rvalid0);
    end
    @(negedge clk); reset = 1'b1;

    access(1'b1, 32'h10, 32'h11111111, 1'b0, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b1, 32'h10, 32'h11111111, exp_rd, exp_err);
    access(1'b0, 32'h10, 32'h0, 1'b0, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b0, 32'h10, 32'h0, exp_rd, exp_err);
    vectors++; if (got_rd !== exp_rd) begin miscompares++; $display("FAIL pre_reset_read: got %h want %h", got_rd, exp_rd); end

    // Start a write of DEADBEEF, then abort it with reset while in the wait states
    @(negedge clk); req = 1'b1; we = 1'b1; a = 32'h10; wd = 32'hDEADBEEF;
    @(negedge clk); req = 1'b0; we = 1'b0;
    #2 reset = 1'b0;
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b want 1", ready); end
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL abort_rvalid: got %b want 0", rvalid); end
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL abort_rd: got %h want 0", rd); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL abort_err: got %b want 0", err); end
    @(negedge clk); reset = 1'b1;

    access(1'b0, 32'h10, 32'h0, 1'b0, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b0, 32'h10, 32'h0, exp_rd, exp_err);
    vectors++; if (got_rd !== exp_rd) begin miscompares++; $display("FAIL abort_not_committed: got %h want %h", got_rd, exp_rd); end
  endtask

  task automatic test_write_read();
    int lat, busy_bad;
    logic [31:0] got_rd, exp_rd;
    logic got_err, exp_err, sr;
    for (int i = 0; i < 2; i++) begin
      access(i == 0, 32'h54, 32'h00000007, 1'b0, lat, busy_bad, got_rd, got_err, sr);
      ref_op(i == 0, 32'h54, 32'h00000007, exp_rd, exp_err);
      vectors++; if (sr !== 1'b1) begin miscompares++; $display("FAIL wr_ready_idle: got %b want 1", sr); end
      vectors++; if (lat != WC + 1) begin miscompares++; $display("FAIL wr_latency: got %0d want %0d", lat, WC + 1); end
      vectors++; if (busy_bad != 0) begin miscompares++; $display("FAIL wr_busy: got %0d cycles with ready!=0 want 0", busy_bad); end
      vectors++; if (got_rd !== exp_rd) begin miscompares++; $display("FAIL wr_rd: got %h want %h", got_rd, exp_rd); end
    end
  endtask

  task automatic test_wrap();
    int lat, busy_bad;
    logic [31:0] got_rd, exp_rd;
    logic got_err, exp_err, sr;
    access(1'b1, 32'h100, 32'h12345678, 1'b0, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b1, 32'h100, 32'h12345678, exp_rd, exp_err);
    access(1'b0, 32'h000, 32'h0, 1'b0, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b0, 32'h000, 32'h0, exp_rd, exp_err);
    vectors++; if (got_rd !== exp_rd) begin miscompares++; $display("FAIL wrap_rd: got %h want %h", got_rd, exp_rd); end
  endtask

  task automatic test_ignored_req();
    int lat, busy_bad, extra;
    logic [31:0] got_rd, exp_rd;
    logic got_err, exp_err, sr;
    access(1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b1, 32'h20, 32'hA5A5A5A5, exp_rd, exp_err);
    access(1'b0, 32'h20, 32'h0, 1'b1, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b0, 32'h20, 32'h0, exp_rd, exp_err);
    vectors++; if (lat != WC + 1) begin miscompares++; $display("FAIL ign_latency: got %0d want %0d", lat, WC + 1); end
    vectors++; if (got_rd !== exp_rd) begin miscompares++; $display("FAIL ign_rd: got %h want %h", got_rd, exp_rd); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rvalid !== 1'b0) extra++;
    end
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL ign_extra_rvalid: got %0d want 0", extra); end
    access(1'b0, 32'h20, 32'h0, 1'b0, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b0, 32'h20, 32'h0, exp_rd, exp_err);
    vectors++; if (got_rd !== exp_rd) begin miscompares++; $display("FAIL ign_mem_unchanged: got %h want %h", got_rd, exp_rd); end
  endtask

  task automatic test_misalign();
    int lat, busy_bad;
    logic [31:0] got_rd, exp_rd;
    logic got_err, exp_err, sr;
    access(1'b1, 32'h20, 32'h0BADF00D, 1'b0, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b1, 32'h20, 32'h0BADF00D, exp_rd, exp_err);
    access(1'b1, 32'h22, 32'hFFFFFFFF, 1'b0, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b1, 32'h22, 32'hFFFFFFFF, exp_rd, exp_err);
    vectors++; if (lat != WC + 1) begin miscompares++; $display("FAIL mis_latency: got %0d want %0d", lat, WC + 1); end
    vectors++; if (got_err !== exp_err) begin miscompares++; $display("FAIL mis_write_err: got %b want %b", got_err, exp_err); end
    access(1'b0, 32'h20, 32'h0, 1'b0, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b0, 32'h20, 32'h0, exp_rd, exp_err);
    vectors++; if (got_rd !== exp_rd || got_err !== exp_err) begin
      miscompares++; $display("FAIL mis_aligned_read: got %h/%b want %h/%b", got_rd, got_err, exp_rd, exp_err);
    end
    access(1'b0, 32'h23, 32'h0, 1'b0, lat, busy_bad, got_rd, got_err, sr);
    ref_op(1'b0, 32'h23, 32'h0, exp_rd, exp_err);
    vectors++; if (got_rd !== exp_rd || got_err !== exp_err) begin
      miscompares++; $display("FAIL mis_read: got %h/%b want %h/%b", got_rd, got_err, exp_rd, exp_err);
    end
  endtask

  task automatic test_random();
    int lat, busy_bad;
    logic [31:0] got_rd, exp_rd, addr, data;
    logic got_err, exp_err, sr;
    bit w;
    for (int i = 0; i < 30; i++) begin
      addr = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      data = $urandom;
      w    = !known[widx(addr)] || ($urandom_range(0, 1) == 1);
      access(w, addr, data, 1'b0, lat, busy_bad, got_rd, got_err, sr);
      ref_op(w, addr, data, exp_rd, exp_err);
      vectors++;
      if (lat != WC + 1 || busy_bad != 0 || got_rd !== exp_rd || got_err !== exp_err) begin
        miscompares++;
        $display("FAIL rand_%0d a=%h we=%b: got lat=%0d busy=%0d rd=%h err=%b want lat=%0d busy=0 rd=%h err=%b",
                 i, addr, w, lat, busy_bad, got_rd, got_err, WC + 1, exp_rd, exp_err);
      end
    end
  endtask

  task automatic test_back_to_back_wait0();
    localparam int N = 10;
    logic [31:0] op_a [N];
    logic [31:0] op_d [N];
    logic [31:0] op_e [N];
    bit          op_w [N];
    logic [31:0] v;
    for (int k = 0; k < N; k += 2) begin
      v = $urandom;
      op_a[k] = ($urandom_range(0, 63) << 2); op_d[k] = v; op_w[k] = 1'b1; op_e[k] = 32'd0;
      op_a[k+1] = op_a[k] + 32'h100; op_d[k+1] = $urandom; op_w[k+1] = 1'b0; op_e[k+1] = v;
    end
    @(negedge clk);
    vectors++; if (ready0 !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_idle: got %b want 1", ready0); end
    req0 = 1'b1; we0 = op_w[0]; a0 = op_a[0]; wd0 = op_d[0];
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      vectors++;
      if (rvalid0 !== 1'b1 || rd0 !== op_e[k] || err0 !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_resp_%0d: got rvalid=%b rd=%h err=%b want 1 %h 0", k, rvalid0, rd0, err0, op_e[k]);
      end
      if (k + 1 < N) begin
        we0 = op_w[k+1]; a0 = op_a[k+1]; wd0 = op_d[k+1];
      end else begin
        req0 = 1'b0;
      end
      @(negedge clk);
      vectors++;
      if (rvalid0 !== 1'b0 || ready0 !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_gap_%0d: got rvalid=%b ready=%b want 0 1", k, rvalid0, ready0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_ignored_req();
    test_misalign();
    test_random();
    test_back_to_back_wait0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
